// File: rtl/slave_in.sv
// Receive side of a serial-bus slave port: deserialises address, burst and
// write data, then issues local memory writes or a read request.
module slave_in #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 selected,
  input  logic                 master_valid,
  input  logic                 rx_address,
  input  logic                 rx_burst,
  input  logic                 rx_data,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 read_done,
  output logic                 slave_ready,
  output logic                 mem_wr,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 read_req,
  output logic [ADDR_LEN-1:0]  read_addr,
  output logic [BURST_LEN-1:0] read_burst,
  output logic                 rx_done
);

  localparam int MAX_LEN = (ADDR_LEN > DATA_LEN)
                         ? ((ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN)
                         : ((DATA_LEN > BURST_LEN) ? DATA_LEN : BURST_LEN);
  localparam int CW = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0] BURST_BITS = CW'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RREQ, RWAIT, DONE} state_t;

  state_t state, next_state;

  logic [CW-1:0]        bit_cnt;
  logic [ADDR_LEN-1:0]  addr_sr;
  logic [BURST_LEN-1:0] burst_sr;
  logic [DATA_LEN-2:0]  data_sr;
  logic [BURST_LEN-1:0] word_idx;
  logic                 mode_wr;
  logic                 words_done;

  logic                 start;
  logic                 addr_last;
  logic                 data_last;
  logic                 last_word;
  logic [ADDR_LEN-1:0]  addr_nx;
  logic [BURST_LEN-1:0] burst_nx;
  logic [DATA_LEN-1:0]  data_nx;
  logic [BURST_LEN-1:0] word_cnt;

  assign start     = selected & master_valid & (write_en ^ read_en);
  assign addr_last = (bit_cnt == ADDR_LAST);
  assign data_last = (bit_cnt == DATA_LAST);
  assign addr_nx   = {rx_address, addr_sr[ADDR_LEN-1:1]};
  // Burst bits beyond BURST_LEN arrive alongside the address but are dropped.
  assign burst_nx  = (bit_cnt < BURST_BITS) ? {rx_burst, burst_sr[BURST_LEN-1:1]} : burst_sr;
  assign data_nx   = {rx_data, data_sr};
  assign word_cnt  = (burst_sr == '0) ? BURST_LEN'(1) : burst_sr;
  assign last_word = (word_idx == word_cnt - BURST_LEN'(1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ADDR;
      ADDR:    if (master_valid && addr_last) next_state = mode_wr ? WDATA : RREQ;
      WDATA:   if (words_done) next_state = DONE;
      RREQ:    next_state = RWAIT;
      RWAIT:   if (read_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt     <= '0;
      addr_sr     <= '0;
      burst_sr    <= '0;
      data_sr     <= '0;
      word_idx    <= '0;
      mode_wr     <= 1'b0;
      words_done  <= 1'b0;
      slave_ready <= 1'b1;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      read_req    <= 1'b0;
      read_addr   <= '0;
      read_burst  <= '0;
      rx_done     <= 1'b0;
    end else begin
      mem_wr      <= 1'b0;
      read_req    <= 1'b0;
      rx_done     <= (next_state == DONE);
      slave_ready <= (next_state == IDLE) || (next_state == ADDR) || (next_state == WDATA);
      case (state)
        IDLE: begin
          if (start) begin
            addr_sr    <= addr_nx;
            burst_sr   <= burst_nx;
            bit_cnt    <= CW'(1);
            mode_wr    <= write_en;
            word_idx   <= '0;
            words_done <= 1'b0;
          end
        end
        ADDR: begin
          if (master_valid) begin
            addr_sr  <= addr_nx;
            burst_sr <= burst_nx;
            if (addr_last) begin
              bit_cnt  <= '0;
              word_idx <= '0;
              if (!mode_wr) begin
                read_req   <= 1'b1;
                read_addr  <= addr_nx;
                read_burst <= (burst_nx == '0) ? BURST_LEN'(1) : burst_nx;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        WDATA: begin
          // After the final word, trailing bits are ignored while DONE is reached.
          if (master_valid && !words_done) begin
            data_sr <= data_nx[DATA_LEN-1:1];
            if (data_last) begin
              bit_cnt    <= '0;
              mem_wr     <= 1'b1;
              mem_wdata  <= data_nx;
              mem_addr   <= addr_sr + ADDR_LEN'(word_idx);
              word_idx   <= word_idx + BURST_LEN'(1);
              words_done <= last_word;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/slave_in.md
Name: slave_in

Overview:
- Receive side of a slave port on the serial system bus.
- Consumes the bit-serial address, burst count and write-data streams driven by a master port's transmit stage.
- Deserialises them and issues parallel word writes to the slave's local memory, or a parallel read request to the slave's transmit stage.
- Signals transaction completion back to the bus.

Parameters:
ADDR_LEN, 12, width of the address and of the local memory address
DATA_LEN, 8, width of one data word
BURST_LEN, 12, width of the burst count

Ports:
clk  input  1  bus clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
selected  input  1  bus decoder says this slave is the addressed target
master_valid  input  1  serial bits on rx_address/rx_burst/rx_data are valid this cycle
rx_address  input  1  serial address bit, LSB first
rx_burst  input  1  serial burst-count bit, LSB first, sent in lockstep with rx_address
rx_data  input  1  serial write-data bit, LSB first
write_en  input  1  transaction is a write (sampled at frame start)
read_en  input  1  transaction is a read (sampled at frame start)
read_done  input  1  slave transmit stage has finished the requested read burst
slave_ready  output  1  slave can accept serial bits
mem_wr  output  1  one-cycle write strobe to local memory
mem_addr  output  ADDR_LEN  write address
mem_wdata  output  DATA_LEN  write data
read_req  output  1  one-cycle read request to transmit stage
read_addr  output  ADDR_LEN  read start address
read_burst  output  BURST_LEN  read word count
rx_done  output  1  one-cycle pulse: transaction complete

Behaviour:
- Reset (reset==0 at a clock edge) forces IDLE. All outputs go to 0 except slave_ready, which goes to 1. Bit counters, shift registers and the word index are cleared. Reset mid-transaction abandons it with no mem_wr, read_req or rx_done.
- Bit shifting happens only on cycles with master_valid==1. A valid==0 cycle holds all counters and shift registers, so the stream may stall anywhere.
- All outputs are registered.
- IDLE:
  - Entered on the first cycle with selected & master_valid & (write_en ^ read_en).
  - That cycle's rx_address/rx_burst bits are captured as bit 0.
  - write_en/read_en are latched into a mode flag.
  - write_en==read_en (both 1 or both 0): request ignored, stay IDLE.
- ADDR:
  - One address bit and one burst bit captured per valid cycle.
  - After ADDR_LEN address bits, the address is complete. BURST_LEN bits are captured in parallel; if BURST_LEN<ADDR_LEN the extra rx_burst bits are ignored.
  - Effective count N = burst value, except burst==0, which is treated as N=1.
  - Write mode: go to WDATA with word index 0.
  - Read mode: go to RREQ.
- WDATA:
  - Shift DATA_LEN bits per word.
  - The cycle after the last bit of a word is captured: mem_wr=1, mem_wdata=word, mem_addr=(base+index) mod 2^ADDR_LEN. Address wraps with no error.
  - The next word's bits may arrive in the same cycle as that mem_wr pulse.
  - After word N, go to DONE.
- RREQ:
  - read_req=1 for exactly one cycle, with read_addr=base and read_burst=N.
  - Then go to RWAIT; slave_ready=0 in RWAIT.
- RWAIT:
  - Wait for read_done==1, then go to DONE.
  - read_done in the same cycle as the read_req pulse is ignored.
- DONE: rx_done=1 for one cycle, slave_ready returns to 1, go to IDLE.
- slave_ready=1 in IDLE, ADDR and WDATA; 0 in RREQ, RWAIT and DONE.
- master_valid while slave_ready==0: bits ignored.
- selected dropping mid-frame: ignored; the frame completes once started.

Test Plan:
- Single write: addr 0x0A5, burst 1, data 0x3C, contiguous valid → after 12+8 bits, mem_wr once with mem_addr 0x0A5, mem_wdata 0x3C; rx_done exactly one cycle later.
- Burst write with stalls: addr 0xFFE, burst 3, words 0x11, 0x22, 0x33, master_valid low every third cycle → mem_wr at 0xFFE/0x11, 0xFFF/0x22, 0x000/0x33 (wrap); one rx_done.
- Burst 0: addr 0x010, burst 0, data 0x5A → exactly one mem_wr (0x010, 0x5A).
- Read: addr 0x123, burst 4 → one read_req with read_addr 0x123, read_burst 4; slave_ready 0 until read_done is driven 10 cycles later; rx_done next cycle.
- Illegal/unselected: write_en=read_en=1, or selected=0, with valid bits → no state change, no strobes, slave_ready stays 1.
- Reset mid-WDATA after 5 data bits → outputs cleared, no mem_wr; a following clean write at 0x001/0x99 completes correctly.
